// File: rtl/core_types_pkg.sv
// Core-wide sizing constants shared by the writeback and register-file logic.
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 7;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int PR_COUNT           = 128;
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int XLEN               = 32;
    localparam int PRF_BANK_ADDR_W    = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

endpackage

// File: rtl/prf_wr_bank_rr_arb.sv
// Round-robin arbiter for one PRF bank write port; search order wraps modulo REQ_COUNT,
// which need not be a power of two.
module prf_wr_bank_rr_arb #(
    parameter  int REQ_COUNT = 7,
    localparam int IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [REQ_COUNT-1:0] req,
    output logic [REQ_COUNT-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] cand_idx_s;
    int               cand_s;
    logic             found_s;

    // First requester at or after rr_ptr wins.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            cand_s = int'(rr_ptr_r) + k;
            if (cand_s >= REQ_COUNT) begin
                cand_s = cand_s - REQ_COUNT;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s           = 1'b1;
                grant[cand_idx_s] = 1'b1;
                grant_idx         = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        grant_valid = found_s;
    end

    // Pointer moves just past the winner; holds when the bank is idle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rr_ptr_r <= '0;
        end else if (grant_valid) begin
            rr_ptr_r <= (grant_idx == IDX_W'(REQ_COUNT - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/prf_wr_arbiter.sv
// Banked PRF write-port arbiter: routes writeback requesters to their bank, arbitrates each bank
// round-robin, and registers the winners onto the bank write ports and the wakeup broadcast.
module prf_wr_arbiter
    import core_types_pkg::*;
(
    input  logic                                             CLK,
    input  logic                                             nRST,
    input  logic [PRF_WR_COUNT-1:0]                          WB_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]        WB_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                WB_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                          WB_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                        prf_wen_by_bank,
    output logic [PRF_BANK_COUNT-1:0][PRF_BANK_ADDR_W-1:0]   prf_waddr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]              prf_wdata_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                        complete_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]      complete_PR_by_bank
);

    localparam int WR_IDX_W = $clog2(PRF_WR_COUNT);

    logic [PRF_WR_COUNT-1:0]    req_s        [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]    grant_s      [PRF_BANK_COUNT];
    logic [WR_IDX_W-1:0]        grant_idx_s  [PRF_BANK_COUNT];
    logic [PRF_BANK_COUNT-1:0]  grant_valid_s;
    logic [LOG_PR_COUNT-1:0]    sel_pr_s     [PRF_BANK_COUNT];
    logic [XLEN-1:0]            sel_data_s   [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]    ready_s;

    logic [PRF_BANK_COUNT-1:0]                      wen_r;
    logic [PRF_BANK_COUNT-1:0][PRF_BANK_ADDR_W-1:0] waddr_r;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]            wdata_r;
    logic [PRF_BANK_COUNT-1:0]                      cvalid_r;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    cpr_r;

    // Request matrix: the low PR bits pick the bank.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            req_s[b] = '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                req_s[b][i] = WB_valid_by_wr[i]
                            & (WB_PR_by_wr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : gen_bank
        prf_wr_bank_rr_arb #(.REQ_COUNT(PRF_WR_COUNT)) u_arb (
            .CLK         (CLK),
            .nRST        (nRST),
            .req         (req_s[b]),
            .grant       (grant_s[b]),
            .grant_idx   (grant_idx_s[b]),
            .grant_valid (grant_valid_s[b])
        );
    end

    // Ready is the OR of all bank grants, blocked while reset is held.
    always_comb begin
        ready_s = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            ready_s = ready_s | grant_s[b];
        end
        if (nRST) begin
            WB_ready_by_wr = ready_s;
        end else begin
            WB_ready_by_wr = '0;
        end
    end

    // Per-bank mux of the winning requester's PR and data.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            sel_pr_s[b]   = WB_PR_by_wr[grant_idx_s[b]];
            sel_data_s[b] = WB_data_by_wr[grant_idx_s[b]];
        end
    end

    // Output stage; PR 0 is hardwired zero, so its grant is consumed without a write or wakeup.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wen_r    <= '0;
            waddr_r  <= '0;
            wdata_r  <= '0;
            cvalid_r <= '0;
            cpr_r    <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (grant_valid_s[b]) begin
                    wen_r[b]    <= (sel_pr_s[b] != '0);
                    cvalid_r[b] <= (sel_pr_s[b] != '0);
                    waddr_r[b]  <= sel_pr_s[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    wdata_r[b]  <= sel_data_s[b];
                    cpr_r[b]    <= sel_pr_s[b];
                end else begin
                    wen_r[b]    <= 1'b0;
                    cvalid_r[b] <= 1'b0;
                end
            end
        end
    end

    assign prf_wen_by_bank        = wen_r;
    assign prf_waddr_by_bank      = waddr_r;
    assign prf_wdata_by_bank      = wdata_r;
    assign complete_valid_by_bank = cvalid_r;
    assign complete_PR_by_bank    = cpr_r;

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Directed bench for prf_wr_arbiter: reset, bank routing, round-robin order, PR 0 and mid-run reset.
module tb_prf_wr_arbiter;
    import core_types_pkg::*;

    logic                                           CLK = 1'b0;
    logic                                           nRST;
    logic [PRF_WR_COUNT-1:0]                        valid;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]      pr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]              data;
    logic [PRF_WR_COUNT-1:0]                        ready;
    logic [PRF_BANK_COUNT-1:0]                      wen;
    logic [PRF_BANK_COUNT-1:0][PRF_BANK_ADDR_W-1:0] waddr;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]            wdata;
    logic [PRF_BANK_COUNT-1:0]                      cvalid;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    cpr;

    int checks = 0;
    int errors = 0;

    prf_wr_arbiter dut (
        .CLK                    (CLK),
        .nRST                   (nRST),
        .WB_valid_by_wr         (valid),
        .WB_PR_by_wr            (pr),
        .WB_data_by_wr          (data),
        .WB_ready_by_wr         (ready),
        .prf_wen_by_bank        (wen),
        .prf_waddr_by_bank      (waddr),
        .prf_wdata_by_bank      (wdata),
        .complete_valid_by_bank (cvalid),
        .complete_PR_by_bank    (cpr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        valid = '0;
        pr    = '0;
        for (int i = 0; i < PRF_WR_COUNT; i++) data[i] = 32'hA000_0000 | 32'(i);
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        valid = '1;
        for (int i = 0; i < PRF_WR_COUNT; i++) pr[i] = 7'(4 * (i + 1));
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ready !== 7'b0) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: got %b expected %b", c, ready, 7'b0);
            end
            tick();
        end
        checks++;
        if (wen !== 4'b0 || cvalid !== 4'b0 || waddr !== '0 || wdata !== '0 || cpr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wen=%b cvalid=%b waddr=%h wdata=%h cpr=%h expected all 0",
                     wen, cvalid, waddr, wdata, cpr);
        end
        nRST = 1'b1;
        #1;
        checks++;
        if (ready !== 7'b0000001 || wen !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b wen=%b expected ready=0000001 wen=0000", ready, wen);
        end
        tick();
        checks++;
        if (wen !== 4'b0001 || cpr[0] !== 7'd4 || waddr[0] !== 5'd1 || wdata[0] !== 32'hA000_0000) begin
            errors++;
            $display("FAIL reset_first_grant: wen=%b cpr0=%0d waddr0=%0d wdata0=%h expected 0001 4 1 a0000000",
                     wen, cpr[0], waddr[0], wdata[0]);
        end
    endtask

    task automatic test_conflict_free();
        apply_reset();
        valid[3:0] = 4'b1111;
        pr[0] = 7'd4;
        pr[1] = 7'd9;
        pr[2] = 7'd14;
        pr[3] = 7'd19;
        #1;
        checks++;
        if (ready !== 7'b0001111) begin
            errors++;
            $display("FAIL cf_ready: got %b expected %b", ready, 7'b0001111);
        end
        tick();
        valid = '0;
        checks++;
        if (wen !== 4'b1111 || cvalid !== 4'b1111) begin
            errors++;
            $display("FAIL cf_wen: wen=%b cvalid=%b expected 1111 1111", wen, cvalid);
        end
        checks++;
        if (waddr[0] !== 5'd1 || waddr[1] !== 5'd2 || waddr[2] !== 5'd3 || waddr[3] !== 5'd4) begin
            errors++;
            $display("FAIL cf_waddr: got %0d %0d %0d %0d expected 1 2 3 4", waddr[0], waddr[1], waddr[2], waddr[3]);
        end
        checks++;
        if (cpr[0] !== 7'd4 || cpr[1] !== 7'd9 || cpr[2] !== 7'd14 || cpr[3] !== 7'd19) begin
            errors++;
            $display("FAIL cf_cpr: got %0d %0d %0d %0d expected 4 9 14 19", cpr[0], cpr[1], cpr[2], cpr[3]);
        end
        checks++;
        if (wdata[2] !== 32'hA000_0002 || wdata[3] !== 32'hA000_0003) begin
            errors++;
            $display("FAIL cf_wdata: got %h %h expected a0000002 a0000003", wdata[2], wdata[3]);
        end
        tick();
        checks++;
        if (wen !== 4'b0 || cvalid !== 4'b0) begin
            errors++;
            $display("FAIL cf_idle: wen=%b cvalid=%b expected 0000 0000", wen, cvalid);
        end
    endtask

    task automatic test_full_conflict();
        int w;
        apply_reset();
        valid = '1;
        for (int i = 0; i < PRF_WR_COUNT; i++) pr[i] = 7'(4 * (i + 1));
        for (int k = 0; k < 8; k++) begin
            w = k % 7;
            #1;
            checks++;
            if (ready !== 7'(1 << w)) begin
                errors++;
                $display("FAIL fc_ready step%0d: got %b expected %b", k, ready, 7'(1 << w));
            end
            tick();
            checks++;
            if (wen !== 4'b0001 || cpr[0] !== 7'(4 * (w + 1)) || waddr[0] !== 5'(w + 1) || wdata[0] !== data[w]) begin
                errors++;
                $display("FAIL fc_write step%0d: wen=%b cpr0=%0d waddr0=%0d wdata0=%h expected 0001 %0d %0d %h",
                         k, wen, cpr[0], waddr[0], wdata[0], 4 * (w + 1), w + 1, data[w]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [PRF_WR_COUNT-1:0] exp;
        apply_reset();
        valid[0] = 1'b1;
        valid[6] = 1'b1;
        pr[0]    = 7'd2;
        pr[6]    = 7'd6;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 7'b0000001 : 7'b1000000;
            #1;
            checks++;
            if (ready !== exp) begin
                errors++;
                $display("FAIL fair_ready step%0d: got %b expected %b", k, ready, exp);
            end
            tick();
            checks++;
            if (wen !== 4'b0100 || cpr[2] !== ((k % 2 == 0) ? 7'd2 : 7'd6)) begin
                errors++;
                $display("FAIL fair_write step%0d: wen=%b cpr2=%0d expected 0100 %0d",
                         k, wen, cpr[2], (k % 2 == 0) ? 2 : 6);
            end
        end
    endtask

    task automatic test_pr_zero();
        apply_reset();
        valid[3] = 1'b1;
        pr[3]    = 7'd0;
        data[3]  = 32'hDEAD_BEEF;
        valid[5] = 1'b1;
        pr[5]    = 7'd8;
        #1;
        checks++;
        if (ready !== 7'b0001000) begin
            errors++;
            $display("FAIL pr0_ready: got %b expected %b", ready, 7'b0001000);
        end
        tick();
        valid[3] = 1'b0;
        checks++;
        if (wen[0] !== 1'b0 || cvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL pr0_suppress: wen0=%b cvalid0=%b expected 0 0", wen[0], cvalid[0]);
        end
        #1;
        checks++;
        if (ready !== 7'b0100000) begin
            errors++;
            $display("FAIL pr0_next_ready: got %b expected %b", ready, 7'b0100000);
        end
        tick();
        valid = '0;
        checks++;
        if (wen !== 4'b0001 || cvalid !== 4'b0001 || cpr[0] !== 7'd8 || waddr[0] !== 5'd2) begin
            errors++;
            $display("FAIL pr0_next_write: wen=%b cvalid=%b cpr0=%0d waddr0=%0d expected 0001 0001 8 2",
                     wen, cvalid, cpr[0], waddr[0]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        valid[2:0] = 3'b111;
        pr[0] = 7'd4;
        pr[1] = 7'd5;
        pr[2] = 7'd6;
        #1;
        checks++;
        if (ready !== 7'b0000111) begin
            errors++;
            $display("FAIL mr_ready_pre: got %b expected %b", ready, 7'b0000111);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (ready !== 7'b0) begin
            errors++;
            $display("FAIL mr_ready_blocked: got %b expected %b", ready, 7'b0);
        end
        tick();
        checks++;
        if (wen !== 4'b0 || cvalid !== 4'b0 || cpr !== '0) begin
            errors++;
            $display("FAIL mr_dropped: wen=%b cvalid=%b cpr=%h expected all 0", wen, cvalid, cpr);
        end
        clear_inputs();
        nRST = 1'b1;
        tick();
        tick();
        checks++;
        if (wen !== 4'b0 || cvalid !== 4'b0) begin
            errors++;
            $display("FAIL mr_no_stale: wen=%b cvalid=%b expected 0000 0000", wen, cvalid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        clear_inputs();
        test_reset();
        test_conflict_free();
        test_full_conflict();
        test_fairness();
        test_pr_zero();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
